// File: rtl/hh_spike_detector.sv
// Action-potential detector for the HH core's membrane voltage: hysteretic onset
// detection, refractory lockout, spike pulse and a small FWFT event FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ARMED   | waiting for v_in >= TH_HI (onset)
// ABOVE   | spike in progress, tracking peak until v_in < TH_HI
// REFRACT | lockout: re-arm once REFRAC samples elapsed and v_in <= TH_LO
module hh_spike_detector #(
    parameter logic signed [13:0] TH_HI  = 14'sd0,
    parameter logic signed [13:0] TH_LO  = -14'sd1600,
    parameter int                 REFRAC = 64,
    parameter int                 DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] v_in,
    input  logic        v_valid,
    input  logic        clr,
    output logic        spike,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [13:0] ev_peak,
    output logic [15:0] ev_isi,
    output logic [7:0]  spike_count,
    output logic        overflow
);
    localparam int RW = $clog2(REFRAC + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [RW-1:0] REF_LOAD = RW'(REFRAC - 1);
    localparam logic [RW-1:0] REF_ZERO = '0;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {ARMED, ABOVE, REFRACT} state_t;

    state_t             state, state_nxt;
    logic signed [13:0] v_s;
    logic signed [13:0] peak;
    logic [15:0]        isi_cnt, isi_lat;
    // Down-counter: loaded on ABOVE exit, terminal count 0 means REFRAC samples done.
    logic [RW-1:0]      ref_tmr;
    logic               onset, exit_above;

    logic [13:0]        peak_mem [DEPTH];
    logic [15:0]        isi_mem  [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               pop, accept, drop;

    assign v_s = v_in;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ARMED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        onset      = 1'b0;
        exit_above = 1'b0;
        if (v_valid) begin
            case (state)
                ARMED: if (v_s >= TH_HI) begin
                    onset     = 1'b1;
                    state_nxt = ABOVE;
                end
                ABOVE: if (v_s < TH_HI) begin
                    exit_above = 1'b1;
                    state_nxt  = REFRACT;
                end
                REFRACT: if (ref_tmr == REF_ZERO && v_s <= TH_LO) state_nxt = ARMED;
                default: state_nxt = ARMED;
            endcase
        end
    end

    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    assign accept   = exit_above & ((count != CNT_FULL) | pop);
    assign drop     = exit_above & ~accept;
    assign ev_peak  = peak_mem[rd_ptr];
    assign ev_isi   = isi_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike       <= 1'b0;
            peak        <= '0;
            isi_cnt     <= 16'hFFFF;
            isi_lat     <= '0;
            ref_tmr     <= '0;
            spike_count <= '0;
            overflow    <= 1'b0;
        end else begin
            spike <= onset;
            if (onset) begin
                peak    <= v_s;
                isi_lat <= isi_cnt;
                isi_cnt <= 16'd1;
            end else begin
                if (v_valid && isi_cnt != 16'hFFFF) isi_cnt <= isi_cnt + 16'd1;
                if (v_valid && state == ABOVE && !exit_above && v_s > peak) peak <= v_s;
            end
            if (exit_above)
                ref_tmr <= REF_LOAD;
            else if (v_valid && state == REFRACT && ref_tmr != REF_ZERO)
                ref_tmr <= ref_tmr - 1'b1;
            if (clr)        spike_count <= onset ? 8'd1 : 8'd0;
            else if (onset) spike_count <= spike_count + 8'd1;
            if (clr)       overflow <= drop;
            else if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                peak_mem[i] <= '0;
                isi_mem[i]  <= '0;
            end
        end else begin
            if (accept) begin
                peak_mem[wr_ptr] <= peak;
                isi_mem[wr_ptr]  <= isi_lat;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_hh_spike_detector.sv
// Randomized self-checking bench for hh_spike_detector against a sample-index
// based reference model with a queue-modelled event FIFO.
module tb_hh_spike_detector;
    localparam int REFRAC = 64;
    localparam int DEPTH  = 4;
    localparam int TH_HI  = 0;
    localparam int TH_LO  = -1600;

    logic        clk = 0, rst_n = 0, v_valid = 0, clr = 0, ev_ready = 0;
    logic [13:0] v_in = 0;
    logic        spike, ev_valid, overflow;
    logic [13:0] ev_peak;
    logic [15:0] ev_isi;
    logic [7:0]  spike_count;

    hh_spike_detector dut (
        .clk(clk), .rst_n(rst_n), .v_in(v_in), .v_valid(v_valid), .clr(clr),
        .spike(spike), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_peak(ev_peak), .ev_isi(ev_isi), .spike_count(spike_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: phase 0 armed, 1 above, 2 refractory; timing by sample index.
    int          m_phase, m_idx, m_last, m_exit, m_peak, m_isi, m_count;
    bit          m_ovf;
    logic [29:0] m_fifo[$];
    logic [29:0] exp_q[$], obs_q[$];
    int          obs_spikes, spike_mis, valid_mis;

    function automatic logic [13:0] mv(input int m);
        return 14'(m * 32);
    endfunction

    function automatic bit q_eq(input logic [29:0] a[$], input logic [29:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_last = -1; m_exit = 0; m_peak = 0; m_isi = 0;
        m_count = 0; m_ovf = 0;
        m_fifo.delete();
    endtask

    task automatic step(input logic [13:0] v, input logic vv, input logic rdy);
        logic        pv;
        logic [29:0] ph, ev;
        bit          onset, pushreq, pop, drop;
        int          vs;
        v_in = v; v_valid = vv; ev_ready = rdy;
        pv = ev_valid; ph = {ev_peak, ev_isi};
        @(posedge clk); #1;
        onset = 0; pushreq = 0; pop = 0; drop = 0; ev = '0;
        if (!rst_n) model_reset();
        else begin
            if (pv && rdy) obs_q.push_back(ph);
            vs = $signed(v);
            if (vv) begin
                m_idx++;
                case (m_phase)
                    0: if (vs >= TH_HI) begin
                        onset = 1;
                        m_isi = (m_last < 0 || m_idx - m_last > 65535) ? 65535 : m_idx - m_last;
                        m_last = m_idx; m_peak = vs; m_phase = 1;
                    end
                    1: if (vs < TH_HI) begin
                        pushreq = 1; ev = {m_peak[13:0], m_isi[15:0]};
                        m_phase = 2; m_exit = m_idx;
                    end else if (vs > m_peak) m_peak = vs;
                    default: if (m_idx - m_exit >= REFRAC && vs <= TH_LO) m_phase = 0;
                endcase
            end
            pop = (m_fifo.size() != 0) && rdy;
            if (pop) exp_q.push_back(m_fifo.pop_front());
            if (pushreq) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(ev);
                else drop = 1;
            end
            m_count = clr ? (onset ? 1 : 0) : (m_count + int'(onset)) % 256;
            if (clr) m_ovf = drop; else if (drop) m_ovf = 1;
        end
        if (spike !== onset) spike_mis++;
        obs_spikes += int'(spike);
        if (ev_valid !== (m_fifo.size() != 0)) valid_mis++;
    endtask

    task automatic send(input logic [13:0] v, input int n, input logic rdy);
        repeat (n) step(v, 1'b1, rdy);
    endtask

    task automatic clear_obs();
        obs_q.delete(); exp_q.delete();
        obs_spikes = 0; spike_mis = 0; valid_mis = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(14'd0, 1'b0, 1'b0);
        step(14'd0, 1'b0, 1'b0);
        rst_n = 1;
        clear_obs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL reset_spike got %b want 0", spike); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
        checks++; if (ev_peak !== 14'd0) begin errors++; $display("FAIL reset_ev_peak got %0d want 0", ev_peak); end
        checks++; if (ev_isi !== 16'd0) begin errors++; $display("FAIL reset_ev_isi got %0d want 0", ev_isi); end
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", spike_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single_ramp();
        do_reset();
        for (int m = -65; m <= 40; m++) step(mv(m), 1'b1, 1'b1);
        for (int m = 39; m >= -70; m--) step(mv(m), 1'b1, 1'b1);
        send(mv(-70), 5, 1'b1);
        checks++; if (obs_spikes != 1) begin errors++; $display("FAIL ramp_pulses got %0d want 1", obs_spikes); end
        checks++; if (spike_count !== 8'd1) begin errors++; $display("FAIL ramp_count got %0d want 1", spike_count); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL ramp_events got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== {14'd1280, 16'hFFFF})
                begin errors++; $display("FAIL ramp_event got %h want %h", obs_q[0], {14'd1280, 16'hFFFF}); end
        end
        checks++; if (spike_mis != 0) begin errors++; $display("FAIL ramp_pulse_timing got %0d mismatches want 0", spike_mis); end
    endtask

    task automatic test_isi();
        logic [13:0] p1, p2;
        do_reset();
        p1 = 14'($urandom_range(1, 4000));
        p2 = 14'($urandom_range(1, 4000));
        send(p1, 1, 1'b1);
        send(mv(-70), 199, 1'b1);
        send(p2, 1, 1'b1);
        send(mv(-70), 70, 1'b1);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL isi_events got %0d want 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== {p1, 16'hFFFF}) begin errors++; $display("FAIL isi_first got %h want %h", obs_q[0], {p1, 16'hFFFF}); end
            checks++; if (obs_q[1] !== {p2, 16'd200}) begin errors++; $display("FAIL isi_second got %h want %h", obs_q[1], {p2, 16'd200}); end
        end
        checks++; if (!q_eq(obs_q, exp_q)) begin errors++; $display("FAIL isi_model got %0d events want %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_refractory();
        int mid;
        do_reset();
        send(mv(20), 1, 1'b1);
        send(mv(-10), 10, 1'b1);
        send(mv(10), 4, 1'b1);
        send(mv(-10), 60, 1'b1);
        mid = obs_spikes;
        send(mv(-70), 5, 1'b1);
        send(mv(20), 1, 1'b1);
        send(mv(-70), 5, 1'b1);
        checks++; if (mid != 1) begin errors++; $display("FAIL refrac_lockout got %0d pulses want 1", mid); end
        checks++; if (obs_spikes != 2) begin errors++; $display("FAIL refrac_total got %0d pulses want 2", obs_spikes); end
        checks++; if (spike_count !== 8'd2) begin errors++; $display("FAIL refrac_count got %0d want 2", spike_count); end
        checks++; if (spike_mis != 0) begin errors++; $display("FAIL refrac_timing got %0d mismatches want 0", spike_mis); end
    endtask

    task automatic test_overflow();
        logic [13:0] pk[6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pk[i] = 14'($urandom_range(1, 4000));
            send(pk[i], 1, 1'b0);
            send(mv(-70), 70, 1'b0);
        end
        checks++; if (spike_count !== 8'd6) begin errors++; $display("FAIL ovf_count got %0d want 6", spike_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", ev_valid); end
        repeat (6) step(14'd0, 1'b0, 1'b1);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL ovf_drained got %0d want 4", obs_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_q[i][29:16] !== pk[i])
                    begin errors++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, obs_q[i][29:16], pk[i]); end
            end
            checks++; if (obs_q[1][15:0] !== 16'd71) begin errors++; $display("FAIL ovf_isi got %0d want 71", obs_q[1][15:0]); end
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", ev_valid); end
        clr = 1;
        step(14'd0, 1'b0, 1'b0);
        clr = 0;
        checks++; if (spike_count !== 8'd0 || overflow !== 1'b0)
            begin errors++; $display("FAIL clr got count %0d ovf %b want 0 0", spike_count, overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(14'($urandom_range(1, 4000)), 1, 1'b0);
            send(mv(-70), 70, 1'b0);
        end
        send(14'($urandom_range(1, 4000)), 1, 1'b0);
        send(mv(-70), 1, 1'b1);
        send(mv(-70), 70, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL fullpop_popped got %0d want 1", obs_q.size()); end
        repeat (6) step(14'd0, 1'b0, 1'b1);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL fullpop_total got %0d want 5", obs_q.size()); end
        checks++; if (!q_eq(obs_q, exp_q)) begin errors++; $display("FAIL fullpop_model got %0d events want %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(mv(-70), 3, 1'b1);
        send(mv(20), 1, 1'b1);
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL mid_onset got %b want 1", spike); end
        rst_n = 0;
        step(mv(25), 1'b1, 1'b1);
        checks++; if ({spike, ev_valid, ev_peak, ev_isi, spike_count, overflow} !== 41'd0)
            begin errors++; $display("FAIL mid_reset got %h want 0", {spike, ev_valid, ev_peak, ev_isi, spike_count, overflow}); end
        rst_n = 1;
        clear_obs();
        send(mv(-30), 80, 1'b1);
        send(mv(-70), 5, 1'b1);
        checks++; if (obs_q.size() != 0 || ev_valid !== 1'b0)
            begin errors++; $display("FAIL mid_no_event got %0d events valid %b want 0 0", obs_q.size(), ev_valid); end
        checks++; if (obs_spikes != 0 || spike_count !== 8'd0)
            begin errors++; $display("FAIL mid_no_spike got %0d pulses count %0d want 0 0", obs_spikes, spike_count); end
    endtask

    task automatic test_gaps();
        logic [13:0] seq[$];
        logic [29:0] qa[$];
        logic [7:0]  ca;
        int          v, pk;
        for (int s = 0; s < 3; s++) begin
            pk = $urandom_range(1, 4000);
            v = -2240;
            while (v < pk) begin seq.push_back(14'(v)); v += $urandom_range(16, 200); end
            seq.push_back(14'(pk));
            v = pk;
            while (v > -2240) begin v -= $urandom_range(16, 200); seq.push_back(14'((v < -2240) ? -2240 : v)); end
            repeat (70 + $urandom_range(0, 100)) seq.push_back(mv(-70));
        end
        do_reset();
        foreach (seq[i]) step(seq[i], 1'b1, 1'b1);
        send(mv(-70), 3, 1'b1);
        qa = obs_q; ca = spike_count;
        checks++; if (!q_eq(obs_q, exp_q) || spike_mis != 0)
            begin errors++; $display("FAIL gaps_ref_model got %0d events %0d pulse mismatches want %0d 0", obs_q.size(), spike_mis, exp_q.size()); end
        checks++; if (qa.size() != 3) begin errors++; $display("FAIL gaps_ref_events got %0d want 3", qa.size()); end
        do_reset();
        foreach (seq[i]) begin
            if ($urandom_range(0, 1) == 1) step(14'($urandom), 1'b0, 1'b1);
            step(seq[i], 1'b1, 1'b1);
        end
        send(mv(-70), 3, 1'b1);
        checks++; if (spike_count !== ca) begin errors++; $display("FAIL gaps_count got %0d want %0d", spike_count, ca); end
        checks++; if (!q_eq(obs_q, qa)) begin errors++; $display("FAIL gaps_events got %0d events want %0d identical", obs_q.size(), qa.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            clr = ($urandom_range(0, 49) == 0);
            step(14'($urandom_range(0, 6000) - 3000), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < ((i < 750) ? 5 : 1));
        end
        clr = 0;
        repeat (6) step(14'd0, 1'b0, 1'b1);
        checks++; if (spike_mis != 0) begin errors++; $display("FAIL rand_pulses got %0d mismatches want 0", spike_mis); end
        checks++; if (valid_mis != 0) begin errors++; $display("FAIL rand_valid got %0d mismatches want 0", valid_mis); end
        checks++; if (!q_eq(obs_q, exp_q)) begin errors++; $display("FAIL rand_events got %0d want %0d matching", obs_q.size(), exp_q.size()); end
        checks++; if (spike_count !== m_count[7:0]) begin errors++; $display("FAIL rand_count got %0d want %0d", spike_count, m_count); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow got %b want %b", overflow, m_ovf); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_ramp();
        test_isi();
        test_refractory();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hh_spike_detector.md
# hh_spike_detector

Downstream consumer of the Hodgkin–Huxley neuron core's membrane voltage (14-bit signed Q9.5, mV). Detects action potentials with hysteresis and a refractory lockout, emits a one-cycle spike pulse, and queues one event per spike (peak voltage plus inter-spike interval) into a small first-word-fall-through FIFO read with a valid/ready handshake. It is the boundary between the analog-style neuron model and the digital readout and IO logic.

## Interface
- TH_HI, 14'sd0 (0.0 mV): rising-crossing threshold, Q9.5 signed.
- TH_LO, -14'sd1600 (-50.0 mV): re-arm threshold, Q9.5 signed; must be below TH_HI.
- REFRAC, 64: minimum number of valid samples spent in REFRACT.
- DEPTH, 4: event FIFO depth, power of two, ≥2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- v_in  in  14  membrane voltage, signed Q9.5.
- v_valid  in  1  v_in is a new sample this cycle.
- clr  in  1  synchronous clear of spike_count and overflow only.
- spike  out  1  one-cycle pulse per detected spike onset.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts head.
- ev_peak  out  14  head event peak voltage, signed Q9.5.
- ev_isi  out  16  head event inter-spike interval, in valid samples.
- spike_count  out  8  spike onsets since reset/clr, wraps 255→0.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- All comparisons are signed 14-bit. Only cycles with v_valid=1 advance the FSM or the counters. With v_valid=0, all state holds.
- FSM states:
  - ARMED (reset state): if v_in ≥ TH_HI, go to ABOVE. On entry, spike=1, spike_count+1, peak←v_in, isi_lat←isi_cnt, isi_cnt←1.
  - ABOVE: peak←max(peak, v_in). If v_in < TH_HI, push {peak, isi_lat} and go to REFRACT with ref_cnt←1.
  - REFRACT: ref_cnt increments, saturating at REFRAC. Return to ARMED on a sample where ref_cnt ≥ REFRAC and v_in ≤ TH_LO. Both conditions must hold on the same sample.
- isi_cnt:
  - 16-bit; increments on every valid sample except onset samples.
  - Saturates at 0xFFFF. Reset value is 0xFFFF, so the first spike after reset reports 0xFFFF.
  - Two onsets N valid samples apart report ISI=N.
- The ABOVE exit sample does not update peak.
- FIFO:
  - FWFT: ev_valid = not empty; ev_peak/ev_isi = head.
  - Pop on ev_valid & ev_ready.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow←1. spike_count is unaffected by a drop.
- clr: spike_count←0 and overflow←0. If an onset coincides with clr, spike_count←1. If a drop coincides with clr, overflow←1. FSM and FIFO are unaffected.
- Reset values: state ARMED; spike=0; ev_valid=0; ev_peak=0; ev_isi=0; spike_count=0; overflow=0; isi_cnt=0xFFFF; FIFO empty.
- Reset mid-spike discards the in-progress event; nothing is pushed.

## Timing
- All outputs are registered.
- spike: high in the cycle after the clock edge that samples the onset.
- Event push: occurs on the edge that samples the ABOVE exit. ev_valid rises one cycle later if the FIFO was empty.
- Pop: head advances on the edge where ev_valid & ev_ready. The next entry is visible in the following cycle.
- Minimum spike-to-spike spacing: REFRAC+2 valid samples (onset, ≥1 ABOVE exit, refractory).
- Throughput: at most one push and one pop per cycle.

## Test plan
- Ramp -65 mV → +40 mV (peak +40.0 = 14'sd1280) → -70 mV, one step per valid sample, ev_ready=1 -> required response:
  - exactly one spike pulse;
  - spike_count=1;
  - one event with ev_peak=1280, ev_isi=0xFFFF.
- Two spikes whose onsets are 200 valid samples apart -> second event ev_isi=200.
- Voltage re-crosses TH_HI at ref_cnt=10 without first dropping to ≤ TH_LO -> no spike. Then go below -50 mV after sample 64, then above 0 mV -> exactly one spike.
- ev_ready=0 with 6 spikes generated -> 4 events held in FIFO; overflow=1; spike_count=6; draining yields the first 4 events in order.
- FIFO full, with the push sample coinciding with ev_ready=1 -> push accepted; overflow stays 0.
- Assert rst_n=0 while in ABOVE -> next cycle: all outputs at reset values; no event emitted after reset is released.
- Toggle v_valid with 50% gaps during a spike -> spike count and ISI values are identical to the gap-free run.
